// File: rtl/phys_reg_free_list_if.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list_if
//
// Bundles the signals that connect the physical register free list to the
// rename stage and to ROB retirement.
//
//   alloc_cnt_i   [1:0]  registers consumed by rename this cycle (0..2)
//   free_regs_i   [63:0] one-hot-per-bit mask of registers returned by retire
//   preg_a_o      [5:0]  lowest-numbered free register
//   preg_b_o      [5:0]  second-lowest free register
//   avail_o       [1:0]  valid entries on preg_a_o/preg_b_o
//   free_count_o  [6:0]  number of free registers
//   err_o                sticky protocol-error flag
//
// master : the rename/retire side (drives requests, observes grants)
// slave  : the free list itself
// ---------------------------------------------------------------------------
interface phys_reg_free_list_if;
  logic [1:0]  alloc_cnt_i;
  logic [63:0] free_regs_i;
  logic [5:0]  preg_a_o;
  logic [5:0]  preg_b_o;
  logic [1:0]  avail_o;
  logic [6:0]  free_count_o;
  logic        err_o;

  modport master (
    output alloc_cnt_i,
    output free_regs_i,
    input  preg_a_o,
    input  preg_b_o,
    input  avail_o,
    input  free_count_o,
    input  err_o
  );

  modport slave (
    input  alloc_cnt_i,
    input  free_regs_i,
    output preg_a_o,
    output preg_b_o,
    output avail_o,
    output free_count_o,
    output err_o
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// ---------------------------------------------------------------------------
// phys_reg_free_list
//
// Pool of the 64 physical registers used by rename. Hands out up to two free
// registers per cycle (lowest numbers first) and folds registers returned by
// ROB retirement back into the pool.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   fl   - phys_reg_free_list_if.slave (alloc_cnt_i, free_regs_i in;
//          preg_a_o, preg_b_o, avail_o, free_count_o, err_o out)
//
// Optional feature: define FREELIST_CHECK_EN to enable the sticky protocol
// error detector on err_o. Without it err_o is tied to 0 and the functional
// behaviour is unchanged.
// ---------------------------------------------------------------------------
module phys_reg_free_list (
  input logic                  clk,
  input logic                  rst,
  phys_reg_free_list_if.slave  fl
);

  // Registers 0..31 hold architectural state out of reset; 32..63 are free.
  localparam logic [63:0] RESET_MAP = {{32{1'b1}}, {32{1'b0}}};

  logic [63:0] free_map;
  logic [6:0]  free_count;
  logic [5:0]  preg_a;
  logic [5:0]  preg_b;
  logic [1:0]  avail;

  logic        grant_ok;
  logic [1:0]  grant_k;
  logic [63:0] free_mask;
  logic [63:0] after_alloc;
  logic [63:0] newly_set;
  logic [63:0] next_map;
  logic [6:0]  added;
  logic [6:0]  next_count;
  logic [5:0]  next_a;
  logic [5:0]  next_b;
  logic        found_a;
  logic        found_b;
  logic [1:0]  next_avail;

  // Grant the request only when it is legal and fully covered by avail;
  // otherwise the whole request is dropped. Allocation clears happen first,
  // then retirement frees are ORed in, so a register freed while being
  // granted ends up free. Register 0 can never enter the pool.
  always_comb begin
    grant_ok    = (fl.alloc_cnt_i != 2'd3) && (fl.alloc_cnt_i <= avail);
    grant_k     = grant_ok ? fl.alloc_cnt_i : 2'd0;
    free_mask   = {fl.free_regs_i[63:1], 1'b0};

    after_alloc = free_map;
    if (grant_k >= 2'd1) after_alloc[preg_a] = 1'b0;
    if (grant_k == 2'd2) after_alloc[preg_b] = 1'b0;

    newly_set   = free_mask & ~after_alloc;
    next_map    = after_alloc | free_mask;

    added = '0;
    for (int i = 1; i < 64; i++) begin
      added = added + {6'd0, newly_set[i]};
    end
    next_count = free_count - {5'd0, grant_k} + added;
    next_avail = (next_count >= 7'd2) ? 2'd2 : next_count[1:0];
  end

  // Pick the two lowest set bits of the next bitmap. Scanning downward lets
  // the last hit win, which is the lowest index. With a single free register
  // both outputs carry it; with none both are 0.
  always_comb begin
    next_a  = '0;
    next_b  = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int i = 63; i >= 1; i--) begin
      if (next_map[i]) begin
        next_a  = 6'(i);
        found_a = 1'b1;
      end
    end
    for (int i = 63; i >= 1; i--) begin
      if (next_map[i] && (6'(i) != next_a)) begin
        next_b  = 6'(i);
        found_b = 1'b1;
      end
    end
    if (found_a && !found_b) next_b = next_a;
  end

  // State and registered outputs; reset restores the initial pool exactly
  // and overrides any allocate/free on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_map   <= RESET_MAP;
      free_count <= 7'd32;
      preg_a     <= 6'd32;
      preg_b     <= 6'd33;
      avail      <= 2'd2;
    end else begin
      free_map   <= next_map;
      free_count <= next_count;
      preg_a     <= next_a;
      preg_b     <= next_b;
      avail      <= next_avail;
    end
  end

  assign fl.preg_a_o     = preg_a;
  assign fl.preg_b_o     = preg_b;
  assign fl.avail_o      = avail;
  assign fl.free_count_o = free_count;

`ifdef FREELIST_CHECK_EN
  logic err;
  logic err_event;

  // Any illegal request, double free, free of register 0, or a register that
  // is granted and returned on the same edge latches the error until reset.
  always_comb begin
    err_event = 1'b0;
    if (fl.alloc_cnt_i == 2'd3)               err_event = 1'b1;
    if (fl.alloc_cnt_i > avail)               err_event = 1'b1;
    if (|(free_mask & free_map))              err_event = 1'b1;
    if (fl.free_regs_i[0])                    err_event = 1'b1;
    if ((grant_k >= 2'd1) && free_mask[preg_a]) err_event = 1'b1;
    if ((grant_k == 2'd2) && free_mask[preg_b]) err_event = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err | err_event;
  end

  assign fl.err_o = err;
`else
  logic unused_free0;
  assign unused_free0 = fl.free_regs_i[0];
  assign fl.err_o     = 1'b0;
`endif

endmodule
